// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises the line, validates the start bit at mid-bit,
// samples eight data bits LSB-first and checks the stop bit before publishing a byte.
module uart_rx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       new_rx_data_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int HALF  = BAUD_DIV >> 1;
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic             sync1_reg;
  logic             rx_s;
  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg;
  logic [7:0]       data_reg;
  logic             new_reg, new_next;
  logic             ferr_reg, ferr_next;
  logic             sample_en;
  logic [7:0]       bit_en;

  // Both flops reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= rx_i;
      rx_s      <= sync1_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    sample_en  = 1'b0;
    new_next   = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end
      S_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = 3'd0;
          state_next = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next  = '0;
          sample_en = 1'b1;
          if (idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            new_next   = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = S_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One write-enable per data bit, selected by the current bit index.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit_en
      assign bit_en[gi] = sample_en && (idx_reg == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      shift_reg <= 8'h00;
      data_reg  <= 8'h00;
      new_reg   <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= (shift_reg & ~bit_en) | ({8{rx_s}} & bit_en);
      new_reg   <= new_next;
      ferr_reg  <= ferr_next;
      // A bad stop bit leaves the previously published byte untouched.
      if (new_next) begin
        data_reg <= shift_reg;
      end
    end
  end

  assign rx_data_o     = data_reg;
  assign new_rx_data_o = new_reg;
  assign frame_err_o   = ferr_reg;
  assign busy_o        = (state_reg != S_IDLE);

endmodule
